// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide unit returning its result as a single write-back beat.
// Define MULDIV_SIGNED_EN to enable two's-complement operation selected by op[2].
module muldiv_unit #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic [ADDR_W-1:0] dest,
    input  logic              abort,
    output logic              busy,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [WIDTH-1:0]  wb_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [1:0]         op_q, op_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]  wb_dest_q, wb_dest_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               div_zero;
    logic [2*WIDTH-1:0] fin;
    logic [WIDTH-1:0]   result;

    // Multiplier in low half, partial product accumulates into the high half.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] s;
        s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {s, p[WIDTH-1:1]};
    endfunction

    // Remainder in high half, dividend shifts out of / quotient shifts into the low half.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   d);
        logic [WIDTH:0] sh;
        logic [WIDTH:0] tr;
        sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        tr = sh - {1'b0, d};
        if (tr[WIDTH]) return {sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0};
        else           return {tr[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    endfunction

`ifdef MULDIV_SIGNED_EN
    logic sa, sb, neg_new;
    logic neg_q, neg_d;

    assign sa      = op[2] & src_a[WIDTH-1];
    assign sb      = op[2] & src_b[WIDTH-1];
    assign mag_a   = sa ? (~src_a + 1'b1) : src_a;
    assign mag_b   = sb ? (~src_b + 1'b1) : src_b;
    // Remainder follows the dividend's sign; products and quotients follow sa^sb.
    assign neg_new = div_zero ? 1'b0 : ((op[1:0] == 2'b11) ? sa : (sa ^ sb));
`else
    logic unused_op_sign;

    assign unused_op_sign = op[2];
    assign mag_a          = src_a;
    assign mag_b          = src_b;
`endif

    assign div_zero = op[1] && (src_b == '0);
    assign busy     = (state_q != S_IDLE);
    assign wb_en    = wb_en_q;
    assign wb_dest  = wb_dest_q;
    assign wb_data  = wb_data_q;

    always_comb begin
        fin = prod_q;
`ifdef MULDIV_SIGNED_EN
        if (neg_q) begin
            if (!op_q[1])      fin = ~prod_q + 1'b1;
            else if (op_q[0])  fin[2*WIDTH-1:WIDTH] = ~prod_q[2*WIDTH-1:WIDTH] + 1'b1;
            else               fin[WIDTH-1:0] = ~prod_q[WIDTH-1:0] + 1'b1;
        end
`endif
        result = op_q[0] ? fin[2*WIDTH-1:WIDTH] : fin[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        op_d      = op_q;
        dest_d    = dest_q;
        opnd_d    = opnd_q;
        prod_d    = prod_q;
        wb_en_d   = 1'b0;
        wb_dest_d = wb_dest_q;
        wb_data_d = wb_data_q;
`ifdef MULDIV_SIGNED_EN
        neg_d     = neg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    op_d    = op[1:0];
                    dest_d  = dest;
                    count_d = '0;
`ifdef MULDIV_SIGNED_EN
                    neg_d   = neg_new;
`endif
                    // Divide by zero preloads quotient=all ones, remainder=dividend.
                    if (div_zero) begin
                        state_d = S_WB;
                        prod_d  = {src_a, {WIDTH{1'b1}}};
                        opnd_d  = '0;
                    end else if (op[1]) begin
                        state_d = S_RUN;
                        prod_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d  = mag_b;
                    end else begin
                        state_d = S_RUN;
                        prod_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d  = mag_a;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else begin
                    prod_d  = op_q[1] ? div_step(prod_q, opnd_q) : mul_step(prod_q, opnd_q);
                    count_d = count_q + 1'b1;
                    if (count_q == CNT_LAST) begin
                        state_d = S_WB;
                        count_d = '0;
                    end
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                if (!abort) begin
                    wb_en_d   = 1'b1;
                    wb_dest_d = dest_q;
                    wb_data_d = result;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            op_q      <= '0;
            dest_q    <= '0;
            opnd_q    <= '0;
            prod_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_dest_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            op_q      <= op_d;
            dest_q    <= dest_d;
            opnd_q    <= opnd_d;
            prod_q    <= prod_d;
            wb_en_q   <= wb_en_d;
            wb_dest_q <= wb_dest_d;
            wb_data_q <= wb_data_d;
        end
    end

`ifdef MULDIV_SIGNED_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) neg_q <= 1'b0;
        else      neg_q <= neg_d;
    end
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: behavioural model with per-cycle compare plus directed literal cases.
// Signed cases are exercised when MULDIV_SIGNED_EN is defined for both bench and design.
module tb_muldiv_unit;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  src_a, src_b;
    logic [ADDR_W-1:0] dest;
    logic              abort;
    logic              busy, wb_en;
    logic [ADDR_W-1:0] wb_dest;
    logic [WIDTH-1:0]  wb_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wb_beats = 0;
    bit cmp_en = 1'b0;

    muldiv_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .dest(dest), .abort(abort), .busy(busy), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (wb_en === 1'b1) wb_beats <= wb_beats + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result straight from the arithmetic definition of each op.
    function automatic logic [15:0] ref_result(input logic [2:0] o, input logic [15:0] a,
                                               input logic [15:0] b);
        logic [31:0] p;
        int sa, sb;
        bit sgn;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = o[2];
`endif
        sa = $signed(a);
        sb = $signed(b);
        if (sgn) p = 32'(sa * sb);
        else     p = {16'h0, a} * {16'h0, b};
        case (o[1:0])
            2'b00: return p[15:0];
            2'b01: return p[31:16];
            2'b10: begin
                if (b == 16'h0) return 16'hFFFF;
                return sgn ? 16'(sa / sb) : a / b;
            end
            default: begin
                if (b == 16'h0) return a;
                return sgn ? 16'(sa % sb) : a % b;
            end
        endcase
    endfunction

    // Model: a count of busy cycles left per accepted op; the beat fires when it reaches zero.
    int                m_rem;
    logic              m_wb_en, m_busy;
    logic [15:0]       m_data, pend_data;
    logic [ADDR_W-1:0] m_dest, pend_dest;

    always @(posedge clk or negedge rst_n) begin : model
        int r;
        if (!rst_n) begin
            m_rem   <= 0;
            m_busy  <= 1'b0;
            m_wb_en <= 1'b0;
            m_data  <= '0;
            m_dest  <= '0;
        end else begin
            r = m_rem;
            m_wb_en <= 1'b0;
            if (r > 0) begin
                if (abort) r = 0;
                else begin
                    r = r - 1;
                    if (r == 0) begin
                        m_wb_en <= 1'b1;
                        m_data  <= pend_data;
                        m_dest  <= pend_dest;
                    end
                end
            end else if (start && !abort) begin
                pend_data <= ref_result(op, src_a, src_b);
                pend_dest <= dest;
                r = (op[1] && src_b == 16'h0) ? 1 : WIDTH + 1;
            end
            m_rem  <= r;
            m_busy <= (r > 0);
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_busy", busy, m_busy);
            chk("cmp_wb_en", wb_en, m_wb_en);
            chk("cmp_wb_dest", wb_dest, m_dest);
            chk("cmp_wb_data", wb_data, m_data);
        end
    end

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run_op(input string name, input logic [2:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [ADDR_W-1:0] d,
                          input logic [15:0] exp, input int exp_lat);
        int n, lat;
        bit seen;
        @(posedge clk); #2;
        start = 1'b1; op = o; src_a = a; src_b = b; dest = d;
        @(posedge clk); #1 n = cyc;
        #1 start = 1'b0;
        seen = 1'b0;
        lat = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (wb_en) begin
                seen = 1'b1;
                lat = cyc - n;
            end
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
            chk({name, "_data"}, wb_data, exp);
            chk({name, "_dest"}, wb_dest, d);
            @(negedge clk);
            chk({name, "_one_cycle"}, wb_en, 1'b0);
            chk({name, "_hold"}, wb_data, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; op = '0; src_a = '0; src_b = '0; dest = '0;
        #1 rst_n = 1'b0;
        #20;
        chk("rst_busy", busy, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_wb_dest", wb_dest, '0);
        chk("rst_wb_data", wb_data, '0);
        @(posedge clk); #2 rst_n = 1'b1;
        cmp_en = 1'b1;

        run_op("mul_lo", 3'b000, 16'h0123, 16'h0045, 3'd3, 16'h4E6F, 17);
        run_op("mul_hi_ff", 3'b001, 16'hFFFF, 16'hFFFF, 3'd1, 16'hFFFE, 17);
        run_op("mul_lo_ff", 3'b000, 16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 17);
        run_op("div", 3'b010, 16'd100, 16'd7, 3'd4, 16'd14, 17);
        run_op("rem", 3'b011, 16'd100, 16'd7, 3'd5, 16'd2, 17);
        run_op("div0_q", 3'b010, 16'h1234, 16'h0000, 3'd6, 16'hFFFF, 1);
        run_op("div0_r", 3'b011, 16'h1234, 16'h0000, 3'd7, 16'h1234, 1);
        run_op("dest0", 3'b000, 16'h0003, 16'h0005, 3'd0, 16'h000F, 17);
`ifdef MULDIV_SIGNED_EN
        run_op("sdiv", 3'b110, 16'hFFF9, 16'h0002, 3'd1, 16'hFFFD, 17);
        run_op("srem", 3'b111, 16'hFFF9, 16'h0002, 3'd2, 16'hFFFF, 17);
        run_op("smul_lo", 3'b100, 16'hFFFD, 16'h0005, 3'd3, 16'hFFF1, 17);
        run_op("smul_hi", 3'b101, 16'hFFFD, 16'h0005, 3'd4, 16'hFFFF, 17);
        run_op("sdiv_ovf", 3'b110, 16'h8000, 16'hFFFF, 3'd5, 16'h8000, 17);
        run_op("srem_ovf", 3'b111, 16'h8000, 16'hFFFF, 3'd6, 16'h0000, 17);
        run_op("sdiv0_r", 3'b111, 16'hFFF9, 16'h0000, 3'd7, 16'hFFF9, 1);
`endif

        // Start held through every RUN and the WB cycle: only the first is accepted.
        b0 = wb_beats;
        @(posedge clk); #2;
        start = 1'b1; op = 3'b000; src_a = 16'h0123; src_b = 16'h0045; dest = 3'd6;
        @(posedge clk); #2;
        src_a = 16'h7777; src_b = 16'h3333; op = 3'b011; dest = 3'd2;
        repeat (17) @(posedge clk);
        #2 start = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        chk("busy_start_beats", 32'(wb_beats - b0), 32'd1);
        chk("busy_start_data", wb_data, 16'h4E6F);
        chk("busy_start_dest", wb_dest, 3'd6);

        // Abort at RUN count 5.
        b0 = wb_beats;
        @(posedge clk); #2;
        start = 1'b1; op = 3'b001; src_a = 16'hABCD; src_b = 16'h1234; dest = 3'd5;
        @(posedge clk); #2 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk); #2 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        chk("abort_beats", 32'(wb_beats - b0), 32'd0);
        chk("abort_data_held", wb_data, 16'h4E6F);

        // Asynchronous reset in the middle of RUN.
        b0 = wb_beats;
        @(posedge clk); #2;
        start = 1'b1; op = 3'b010; src_a = 16'h9999; src_b = 16'h0003; dest = 3'd7;
        @(posedge clk); #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_wb_en", wb_en, 1'b0);
        chk("midrst_wb_dest", wb_dest, '0);
        chk("midrst_wb_data", wb_data, '0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        chk("midrst_beats", 32'(wb_beats - b0), 32'd0);

        // Random traffic; the per-cycle compare against the model does the checking.
        for (int k = 0; k < 4000; k++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            op    = 3'($urandom_range(0, 7));
            src_a = pick();
            src_b = pick();
            dest  = 3'($urandom_range(0, 7));
            abort = ($urandom_range(0, 59) == 0);
        end
        @(posedge clk); #2;
        start = 1'b0;
        abort = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);
        chk("final_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
